// File: rtl/port_rd_scheduler_if.sv
// Purpose : bundles the scheduler's queue-manager, packet-memory and output-stream signals.
// Latency : wires only; no storage.
// Backpressure: none. The queue manager stalls the scheduler by withholding pkt_ack, and the output side cannot stall.
// Modports: slave = the scheduler (port_rd_scheduler); master = the environment (queue manager, memory, sink).
interface port_rd_scheduler_if;
  logic        sched_mode;      // 0 = strict priority, 1 = round-robin
  logic [7:0]  queue_nonempty;  // bit i: queue i holds a packet
  logic        pkt_req;         // descriptor request
  logic [2:0]  pkt_qid;         // queue being requested
  logic        pkt_ack;         // descriptor valid this cycle
  logic [10:0] pkt_len;         // length in 16-bit words, 0..1024
  logic [15:0] pkt_addr;        // first word address
  logic        mem_rd_en;       // packet memory read strobe
  logic [15:0] mem_rd_addr;     // read address
  logic [15:0] mem_rd_data;     // read data, one cycle after mem_rd_en
  logic        out_ready;       // pulse one cycle before the first beat
  logic        out_data_vld;    // data beat valid
  logic [15:0] out_data;        // data beat
  logic        end_of_packet;   // marks the last beat
  logic        busy;            // scheduler not idle

  modport slave (
    input  sched_mode, queue_nonempty, pkt_ack, pkt_len, pkt_addr, mem_rd_data,
    output pkt_req, pkt_qid, mem_rd_en, mem_rd_addr,
           out_ready, out_data_vld, out_data, end_of_packet, busy
  );

  modport master (
    output sched_mode, queue_nonempty, pkt_ack, pkt_len, pkt_addr, mem_rd_data,
    input  pkt_req, pkt_qid, mem_rd_en, mem_rd_addr,
           out_ready, out_data_vld, out_data, end_of_packet, busy
  );
endinterface

// File: rtl/port_rd_scheduler.sv
// Purpose : selects one of 8 queues (strict priority or round-robin), fetches its descriptor and streams the packet out of memory.
// Latency : grant to pkt_req takes 1 cycle. From pkt_ack, out_ready follows 1 cycle later and the first beat 2 cycles later. There is 1 beat per cycle, and busy drops 2 cycles after the last read.
// Backpressure: the block waits in REQ indefinitely for pkt_ack. The output stream has no backpressure.
// Ports: clk, rst_n (async, active-low); bus = port_rd_scheduler_if.slave (queue manager, memory, output stream).
module port_rd_scheduler (
  input  logic                  clk,
  input  logic                  rst_n,
  port_rd_scheduler_if.slave    bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]  state_q,  state_d;
  logic [2:0]  qid_q,    qid_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0] addr_q,   addr_d;    // address of the read issued this cycle
  logic [10:0] cnt_q,    cnt_d;     // reads still to issue, counting the current one
  logic        vld_q,    vld_d;
  logic        eop_q,    eop_d;

  logic [2:0]  sp_sel;
  logic [2:0]  rr_sel;
  logic [2:0]  rr_idx;
  logic        rd_en;

  // Strict priority: the highest set bit wins, so the last hit in an ascending scan is kept.
  // Round-robin: scan from rr_ptr+8 down to rr_ptr+1 so that the nearest queue after rr_ptr is the last hit kept.
  always_comb begin
    sp_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.queue_nonempty[i]) sp_sel = 3'(i);
    end
    rr_sel = 3'd0;
    rr_idx = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      rr_idx = rr_ptr_q + 3'(k);
      if (bus.queue_nonempty[rr_idx]) rr_sel = rr_idx;
    end
  end

  assign rd_en = (state_q == S_START) || (state_q == S_XFER);

  always_comb begin
    state_d  = state_q;
    qid_d    = qid_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    vld_d    = rd_en;
    eop_d    = rd_en && (cnt_q == 11'd1);
    case (state_q)
      S_IDLE: begin
        if (bus.queue_nonempty != 8'd0) begin
          qid_d   = bus.sched_mode ? rr_sel : sp_sel;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.pkt_ack) begin
          rr_ptr_d = qid_q;
          if (bus.pkt_len == 11'd0) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = bus.pkt_addr;
            cnt_d   = bus.pkt_len;
            state_d = S_START;
          end
        end
      end
      S_START, S_XFER: begin
        addr_d  = addr_q + 16'd1;
        cnt_d   = cnt_q - 11'd1;
        state_d = (cnt_q == 11'd1) ? S_GAP : S_XFER;
      end
      S_GAP: begin
        // Drains the beat of the final read.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      qid_q    <= 3'd0;
      rr_ptr_q <= 3'd7;
      addr_q   <= 16'd0;
      cnt_q    <= 11'd0;
      vld_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      qid_q    <= qid_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      eop_q    <= eop_d;
    end
  end

  assign bus.pkt_req       = (state_q == S_REQ);
  assign bus.pkt_qid       = qid_q;
  assign bus.mem_rd_en     = rd_en;
  assign bus.mem_rd_addr   = rd_en ? addr_q : 16'd0;
  assign bus.out_ready     = (state_q == S_START);
  assign bus.out_data_vld  = vld_q;
  // Gating with the valid flag keeps out_data at 0 whenever the memory bus carries no data for us, including during reset.
  assign bus.out_data      = vld_q ? bus.mem_rd_data : 16'd0;
  assign bus.end_of_packet = eop_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule
